wave_capture_buffer: RTL
========================

Name: wave_capture_buffer

Overview:
- Writer side of the waveform path: captures 8-bit samples after a rising-edge level trigger into a ping-pong line buffer.
- Replays the held waveform, one sample per pixel column, on wave_data for the video display block.
- Single clock domain (pixel_clk).
- Buffer swaps only at frame start, so a frame never shows a partially captured trace.

Parameters:
- X_START, 9, first active column; maps to buffer address 0.
- X_END, 1911, last active column; DEPTH = X_END-X_START+1 = 1903.
- ADDR_W, 11, buffer address width.
- AUTO_TIMEOUT, 65535, accepted samples without a trigger before forced capture (AUTO_TRIG_EN only).

Ports:
- pixel_clk  in  1  clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- sample_in  in  8  unsigned sample.
- sample_valid  in  1  sample_in qualifier, one-cycle strobe.
- decim  in  8  keep 1 of every decim+1 valid samples; 0 = keep all.
- trig_level  in  8  trigger threshold.
- arm  in  1  level; high = continuous capture, low = stop after current capture.
- pixel_xpos  in  12  current column.
- pixel_ypos  in  12  current row.
- wave_data  out  8  sample for the presented column.
- capture_done  out  1  one-cycle pulse on buffer swap.
- buf_sel  out  1  index of the buffer currently displayed.

Behaviour:
- Reset values:
  - state IDLE; wave_data 0; capture_done 0; buf_sel 0.
  - disp_valid 0; decimation counter 0; write address 0; prev_sample 0.
  - RAM contents are not reset.
- Decimation:
  - counter advances on each sample_valid.
  - A sample is "accepted" when counter==0; counter wraps at decim.
  - A decim change takes effect at the next wrap.
- Trigger:
  - evaluated on accepted samples only.
  - fires when prev_sample < trig_level && sample_in >= trig_level.
  - prev_sample updates on every accepted sample.
  - trig_level 0 never fires, because the < test fails.
- FSM:
  - IDLE: when arm=1, go to WAIT_TRIG.
  - WAIT_TRIG: on trigger, write the triggering sample to addr 0, set addr=1, go to CAPTURE.
  - CAPTURE: each accepted sample is written to the back buffer at addr, then addr+1. After the write to addr DEPTH-1, go to HOLD.
  - HOLD: wait for the cycle with pixel_xpos==0 && pixel_ypos==0. On that cycle:
    - toggle buf_sel;
    - set disp_valid=1;
    - pulse capture_done for one cycle;
    - next state is WAIT_TRIG if arm=1, else IDLE.
  - Deasserting arm during WAIT_TRIG returns to IDLE next cycle. Deasserting it during CAPTURE or HOLD does not abort.
- Write target is always the buffer ~buf_sel. The displayed buffer is never written.
- Read side:
  - rd_addr = pixel_xpos - X_START when X_START <= pixel_xpos <= X_END, else outside.
  - wave_data is registered and valid exactly 1 cycle after pixel_xpos is presented.
  - wave_data = 0 for outside columns, or when disp_valid=0.
  - Reads are independent of FSM state.
- Width rules: address compares use 12-bit zero extension. Samples are unsigned throughout.
- Simultaneous events:
  - frame-start cycle coincident with the final CAPTURE write: the swap waits for the next frame start (HOLD is entered first).
  - an accepted sample arriving on the swap cycle is ignored for triggering, but does update prev_sample.
- Reset mid-capture returns everything to its reset values. The display shows 0 until a new capture completes.

Optional Feature:
- AUTO_TRIG_EN defined:
  - WAIT_TRIG counts accepted samples.
  - After AUTO_TIMEOUT accepted samples without a trigger, the next accepted sample is treated as a trigger.
  - Counter clears on entry to WAIT_TRIG.
- Undefined: no counter. WAIT_TRIG waits indefinitely.

Test Plan:
- Reset, arm=0, sweep pixel_xpos 0..1919 -> wave_data 0 everywhere, capture_done never pulses.
- arm=1, decim=0, trig_level=128, ramp 0..255 repeating with sample_valid every cycle -> trigger at sample 128. After the next frame start, capture_done pulses once and buf_sel=1. Column 9 gives 128 one cycle later, column 10 gives 129. Column 8 and column 1912 give 0.
- decim=3, same ramp -> stored samples step by 4 (col9=128, col10=132). Trigger is evaluated only on every 4th sample.
- Capture completes mid-frame, then samples keep changing -> wave_data unchanged until pixel (0,0). The swap happens exactly on that cycle.
- arm dropped during CAPTURE -> capture finishes, swaps, then the FSM idles. A second frame with no further capture_done shows the same data.
- AUTO_TRIG_EN, AUTO_TIMEOUT=16, constant input 50 -> capture starts on the 17th accepted sample. Without the macro there is no capture.

Source files
------------

// File: rtl/wave_capture_buffer_if.sv
// Sample stream, trigger controls and pixel-column read bus of the waveform capture buffer.
// Latency: none (wires only); wave_data is registered inside the buffer.
// Backpressure: none; samples are strobed by sample_valid and are never stalled.
interface wave_capture_buffer_if;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic [7:0]  decim;
    logic [7:0]  trig_level;
    logic        arm;
    logic [11:0] pixel_xpos;
    logic [11:0] pixel_ypos;
    logic [7:0]  wave_data;
    logic        capture_done;
    logic        buf_sel;

    // Sample source / video timing side
    modport master (
        output sample_in, sample_valid, decim, trig_level, arm, pixel_xpos, pixel_ypos,
        input  wave_data, capture_done, buf_sel
    );

    // Capture buffer side
    modport slave (
        input  sample_in, sample_valid, decim, trig_level, arm, pixel_xpos, pixel_ypos,
        output wave_data, capture_done, buf_sel
    );
endinterface

// File: rtl/wave_capture_buffer.sv
// Triggered ping-pong waveform capture; replays the held trace one sample per pixel column.
// Latency: wave_data 1 cycle after pixel_xpos; capture becomes visible at the next frame start.
// Backpressure: none; accepted samples are written or dropped. Define AUTO_TRIG_EN for timeout auto-trigger.
module wave_capture_buffer #(
    parameter int X_START      = 9,
    parameter int X_END        = 1911,
    parameter int ADDR_W       = 11,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic                  pixel_clk,
    input  logic                  sys_rst_n,
    wave_capture_buffer_if.slave  bus
);
    localparam int DEPTH = X_END - X_START + 1;

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [7:0]        dec_cnt_q, dec_cnt_d;
    logic [7:0]        dec_lim_q, dec_lim_d;
    logic [7:0]        prev_q, prev_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              buf_sel_q, buf_sel_d;
    logic              disp_valid_q, disp_valid_d;
    logic              done_q, done_d;
    logic [7:0]        wave_q, wave_d;

    logic              accept;
    logic              level_trig;
    logic              auto_fire;
    logic              fire;
    logic              frame_start;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic              rd_in_range;
    logic [ADDR_W-1:0] rd_addr;

    // Two banks side by side; the top address bit selects the bank.
    logic [7:0] mem [0:(2**(ADDR_W+1))-1];

    assign accept      = bus.sample_valid && (dec_cnt_q == 8'd0);
    assign level_trig  = accept && (prev_q < bus.trig_level) && (bus.sample_in >= bus.trig_level);
    assign frame_start = (bus.pixel_xpos == 12'd0) && (bus.pixel_ypos == 12'd0);
    assign fire        = level_trig || auto_fire;

`ifdef AUTO_TRIG_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    assign auto_fire = accept && (to_cnt_q == TO_W'(AUTO_TIMEOUT));

    // Count accepted samples while waiting; cleared in every other state so WAIT_TRIG entry starts at 0
    always_comb begin
        to_cnt_d = '0;
        if (state_q == WAIT_TRIG) begin
            to_cnt_d = to_cnt_q;
            if (accept && (to_cnt_q != TO_W'(AUTO_TIMEOUT))) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    // Timeout counter register
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) to_cnt_q <= '0;
        else            to_cnt_q <= to_cnt_d;
    end
`else
    assign auto_fire = 1'b0;

    // The timeout only matters with auto-trigger; this block merely consumes the parameter.
    if (AUTO_TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // Decimation: the limit is latched on the accepted sample, so a decim change applies from the next wrap
    always_comb begin
        logic [7:0] lim_eff;
        dec_cnt_d = dec_cnt_q;
        dec_lim_d = dec_lim_q;
        prev_d    = prev_q;
        lim_eff   = (dec_cnt_q == 8'd0) ? bus.decim : dec_lim_q;
        if (bus.sample_valid) begin
            if (dec_cnt_q == 8'd0) dec_lim_d = bus.decim;
            dec_cnt_d = (dec_cnt_q >= lim_eff) ? 8'd0 : dec_cnt_q + 8'd1;
        end
        if (accept) prev_d = bus.sample_in;
    end

    // Capture FSM next state; writes always target the back bank ~buf_sel
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        buf_sel_d    = buf_sel_q;
        disp_valid_d = disp_valid_q;
        done_d       = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.arm) state_d = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                if (!bus.arm) begin
                    state_d = IDLE;
                end else if (fire) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    addr_d  = ADDR_W'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (addr_q == ADDR_W'(DEPTH - 1)) begin
                        addr_d  = '0;
                        state_d = HOLD;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            HOLD: begin
                // Swap only at frame start so a frame never mixes two traces
                if (frame_start) begin
                    buf_sel_d    = ~buf_sel_q;
                    disp_valid_d = 1'b1;
                    done_d       = 1'b1;
                    state_d      = bus.arm ? WAIT_TRIG : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_in_range = (bus.pixel_xpos >= 12'(X_START)) && (bus.pixel_xpos <= 12'(X_END));
    assign rd_addr     = ADDR_W'(bus.pixel_xpos - 12'(X_START));

    // Read the displayed bank; blank outside the active columns or before the first capture
    always_comb begin
        wave_d = '0;
        if (disp_valid_q && rd_in_range) wave_d = mem[{buf_sel_q, rd_addr}];
    end

    // Control and output registers
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            dec_cnt_q    <= '0;
            dec_lim_q    <= '0;
            prev_q       <= '0;
            addr_q       <= '0;
            buf_sel_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            done_q       <= 1'b0;
            wave_q       <= '0;
        end else begin
            state_q      <= state_d;
            dec_cnt_q    <= dec_cnt_d;
            dec_lim_q    <= dec_lim_d;
            prev_q       <= prev_d;
            addr_q       <= addr_d;
            buf_sel_q    <= buf_sel_d;
            disp_valid_q <= disp_valid_d;
            done_q       <= done_d;
            wave_q       <= wave_d;
        end
    end

    // Sample RAM write port; contents are deliberately not reset
    always_ff @(posedge pixel_clk) begin
        if (wr_en) mem[{~buf_sel_q, wr_idx}] <= bus.sample_in;
    end

    assign bus.wave_data    = wave_q;
    assign bus.capture_done = done_q;
    assign bus.buf_sel      = buf_sel_q;
endmodule
